// File: rtl/picorv32_mem_pkg.sv
// Shared types and widths for the PicoRV32 memory model: FSM states,
// bus widths and the saturating statistics counter helper.
package picorv32_mem_pkg;

    localparam int WORD_W = 32;
    localparam int STRB_W = 4;
    localparam int CNT_W  = 32;
    localparam int LAT_W  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        return (&value) ? value : value + 1'b1;
    endfunction

endpackage

// File: rtl/picorv32_mem_array.sv
// Single-port word storage with per-byte write strobes and combinational read.
// Each byte lane is its own array so strobed writes map onto plain RAM.
module picorv32_mem_array
    import picorv32_mem_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [STRB_W-1:0] wstrb,
    input  logic [AW-1:0]     addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    genvar gi;
    generate
        for (gi = 0; gi < STRB_W; gi++) begin : g_lane
            logic [7:0] lane [DEPTH];

            always_ff @(posedge clk) begin
                if (we && wstrb[gi]) begin
                    lane[addr] <= wdata[gi*8 +: 8];
                end
            end

            assign rdata[gi*8 +: 8] = lane[addr];
        end
    endgenerate

endmodule

// File: rtl/picorv32_mem_model.sv
// PicoRV32 native-interface memory model: programmable response latency,
// domem stall gate, range checking, sticky error flag and saturating statistics.
module picorv32_mem_model
    import picorv32_mem_pkg::*;
#(
    parameter int       MEMORY_WORDS = 1024,
    parameter int       LATENCY      = 2,
    parameter bit [0:0] CHECK_RANGE  = 1'b1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              domem,
    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic [WORD_W-1:0] mem_addr,
    input  logic [WORD_W-1:0] mem_wdata,
    input  logic [STRB_W-1:0] mem_wstrb,
    output logic [WORD_W-1:0] mem_rdata,
    output logic              err,
    output logic [CNT_W-1:0]  rd_count,
    output logic [CNT_W-1:0]  wr_count
);

    localparam int AW = $clog2(MEMORY_WORDS);

    state_t              state_reg, state_next;
    logic [LAT_W-1:0]    cnt_reg, cnt_next;
    logic [AW-1:0]       addr_reg, addr_next;
    logic [WORD_W-1:0]   wdata_reg, wdata_next;
    logic [STRB_W-1:0]   wstrb_reg, wstrb_next;
    logic                oor_reg, oor_next;
    logic                ready_reg, ready_next;
    logic [WORD_W-1:0]   rdata_reg, rdata_next;
    logic                err_reg, err_next;
    logic [CNT_W-1:0]    rd_count_reg, rd_count_next;
    logic [CNT_W-1:0]    wr_count_reg, wr_count_next;

    logic                mem_we;
    logic [WORD_W-1:0]   arr_rdata;
    logic [WORD_W-1:0]   merged_word;
    logic [29:0]         word_index;
    logic                index_oor;
    logic                unused_addr_bits;

    assign word_index       = mem_addr[WORD_W-1:2];
    assign unused_addr_bits = ^mem_addr[1:0];
    // Bits above the array width are only meaningful when range checking;
    // otherwise they are discarded and the index wraps.
    assign index_oor        = CHECK_RANGE && ((word_index >> AW) != '0);

    picorv32_mem_array #(
        .DEPTH (MEMORY_WORDS),
        .AW    (AW)
    ) u_array (
        .clk   (clk),
        .we    (mem_we),
        .wstrb (wstrb_reg),
        .addr  (addr_reg),
        .wdata (wdata_reg),
        .rdata (arr_rdata)
    );

    // Word as it will look after this transaction; equals the stored word for reads.
    genvar gi;
    generate
        for (gi = 0; gi < STRB_W; gi++) begin : g_merge
            assign merged_word[gi*8 +: 8] = wstrb_reg[gi] ? wdata_reg[gi*8 +: 8]
                                                          : arr_rdata[gi*8 +: 8];
        end
    endgenerate

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            addr_reg     <= '0;
            wdata_reg    <= '0;
            wstrb_reg    <= '0;
            oor_reg      <= 1'b0;
            ready_reg    <= 1'b0;
            rdata_reg    <= '0;
            err_reg      <= 1'b0;
            rd_count_reg <= '0;
            wr_count_reg <= '0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            addr_reg     <= addr_next;
            wdata_reg    <= wdata_next;
            wstrb_reg    <= wstrb_next;
            oor_reg      <= oor_next;
            ready_reg    <= ready_next;
            rdata_reg    <= rdata_next;
            err_reg      <= err_next;
            rd_count_reg <= rd_count_next;
            wr_count_reg <= wr_count_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        addr_next     = addr_reg;
        wdata_next    = wdata_reg;
        wstrb_next    = wstrb_reg;
        oor_next      = oor_reg;
        ready_next    = 1'b0;
        rdata_next    = '0;
        err_next      = err_reg;
        rd_count_next = rd_count_reg;
        wr_count_next = wr_count_reg;
        mem_we        = 1'b0;

        case (state_reg)
            IDLE: begin
                if (mem_valid) begin
                    addr_next  = word_index[AW-1:0];
                    wdata_next = mem_wdata;
                    wstrb_next = mem_wstrb;
                    oor_next   = index_oor;
                    cnt_next   = LAT_W'(LATENCY);
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (!mem_valid) begin
                    // CPU withdrew the request: protocol error, nothing committed.
                    err_next   = 1'b1;
                    cnt_next   = '0;
                    state_next = IDLE;
                end else if (domem) begin
                    if (cnt_reg != '0) begin
                        cnt_next = cnt_reg - 1'b1;
                    end else begin
                        state_next = RESP;
                        ready_next = 1'b1;
                        mem_we     = (wstrb_reg != '0) && !oor_reg;
                        rdata_next = oor_reg ? '0 : merged_word;
                        err_next   = err_reg | oor_reg;
                    end
                end
            end
            RESP: begin
                state_next = IDLE;
                if (wstrb_reg != '0) begin
                    wr_count_next = sat_inc(wr_count_reg);
                end else begin
                    rd_count_next = sat_inc(rd_count_reg);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign mem_ready = ready_reg;
    assign mem_rdata = rdata_reg;
    assign err       = err_reg;
    assign rd_count  = rd_count_reg;
    assign wr_count  = wr_count_reg;

endmodule

// File: tb/tb_picorv32_mem_model.sv
// Scoreboard bench for picorv32_mem_model: a LATENCY=2 instance for the main
// flows and a LATENCY=0 instance for the domem stall case.
module tb_picorv32_mem_model;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        domem = 1'b1;
    logic        valid = 1'b0;
    logic        sel = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;

    logic        ready2, ready0, err2, err0;
    logic [31:0] rdata2, rdata0, rdc2, rdc0, wrc2, wrc0;
    logic        valid2, valid0;
    logic        ready, err;
    logic [31:0] rdata, rd_count, wr_count;

    typedef struct {
        logic [31:0] rdata;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    assign valid2   = valid & ~sel;
    assign valid0   = valid & sel;
    assign ready    = sel ? ready0 : ready2;
    assign err      = sel ? err0 : err2;
    assign rdata    = sel ? rdata0 : rdata2;
    assign rd_count = sel ? rdc0 : rdc2;
    assign wr_count = sel ? wrc0 : wrc2;

    picorv32_mem_model #(.MEMORY_WORDS(1024), .LATENCY(2), .CHECK_RANGE(1'b1)) u_dut (
        .clk       (clk),
        .resetn    (resetn),
        .domem     (domem),
        .mem_valid (valid2),
        .mem_ready (ready2),
        .mem_addr  (addr),
        .mem_wdata (wdata),
        .mem_wstrb (wstrb),
        .mem_rdata (rdata2),
        .err       (err2),
        .rd_count  (rdc2),
        .wr_count  (wrc2)
    );

    picorv32_mem_model #(.MEMORY_WORDS(1024), .LATENCY(0), .CHECK_RANGE(1'b1)) u_dut_lat0 (
        .clk       (clk),
        .resetn    (resetn),
        .domem     (domem),
        .mem_valid (valid0),
        .mem_ready (ready0),
        .mem_addr  (addr),
        .mem_wdata (wdata),
        .mem_wstrb (wstrb),
        .mem_rdata (rdata0),
        .err       (err0),
        .rd_count  (rdc0),
        .wr_count  (wrc0)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetn = 1'b0;
        valid  = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic do_req(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input logic [31:0] exp_rdata, input int exp_lat, input int stall);
        exp_t e;
        int   n;
        bit   seen;
        @(negedge clk);
        addr  = a;
        wdata = d;
        wstrb = s;
        valid = 1'b1;
        e.rdata = exp_rdata;
        e.lat   = exp_lat;
        sb.push_back(e);
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (n == 1 && stall > 0) domem = 1'b0;
            if (n == 1 + stall) domem = 1'b1;
            if (ready) begin
                seen = 1'b1;
                e = sb.pop_front();
                check_eq("latency", 32'(n), 32'(e.lat));
                check_eq("rdata", rdata, e.rdata);
                valid = 1'b0;
                $display("txn dut=%0d addr=%h wstrb=%b rdata=%h cycles=%0d", sel, a, s, rdata, n);
            end else if (n == 1) begin
                check_eq("rdata_outside_resp", rdata, 32'h0);
            end
        end
        if (!seen) begin
            check_eq("ready_timeout", 32'd0, 32'd1);
            void'(sb.pop_front());
            valid = 1'b0;
            domem = 1'b1;
        end
        @(posedge clk);
        #1;
        check_eq("ready_one_cycle", {31'd0, ready}, 32'd0);
        check_eq("rdata_after_resp", rdata, 32'h0);
    endtask

    task automatic do_abort(input logic [31:0] a);
        bit got_ready;
        @(negedge clk);
        addr  = a;
        wdata = 32'h0;
        wstrb = 4'h0;
        valid = 1'b1;
        @(posedge clk);
        #1;
        valid     = 1'b0;
        got_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (ready) got_ready = 1'b1;
        end
        check_eq("abort_no_ready", {31'd0, got_ready}, 32'd0);
        check_eq("abort_err", {31'd0, err}, 32'd1);
        $display("txn dut=%0d addr=%h aborted err=%0d", sel, a, err);
    endtask

    initial begin
        #25;
        sel = 1'b0;
        #1;
        check_eq("rst_ready", {31'd0, ready}, 32'd0);
        check_eq("rst_rdata", rdata, 32'h0);
        check_eq("rst_err", {31'd0, err}, 32'd0);
        check_eq("rst_rd_count", rd_count, 32'd0);
        check_eq("rst_wr_count", wr_count, 32'd0);
        sel = 1'b1;
        #1;
        check_eq("rst_ready_lat0", {31'd0, ready}, 32'd0);
        check_eq("rst_wr_count_lat0", wr_count, 32'd0);
        sel = 1'b0;
        @(negedge clk);
        resetn = 1'b1;

        // Full-word write then read back, latency 2 -> response in cycle t+4.
        do_req(32'h10, 32'hDEADBEEF, 4'b1111, 32'hDEADBEEF, 4, 0);
        do_req(32'h10, 32'h0, 4'b0000, 32'hDEADBEEF, 4, 0);
        check_eq("wr_count_1", wr_count, 32'd1);
        check_eq("rd_count_1", rd_count, 32'd1);
        check_eq("err_clean", {31'd0, err}, 32'd0);

        // Partial strobes over a cleared word.
        do_req(32'h0, 32'h0, 4'b1111, 32'h0, 4, 0);
        do_req(32'h0, 32'h11223344, 4'b0101, 32'h00220044, 4, 0);
        do_req(32'h0, 32'h0, 4'b0000, 32'h00220044, 4, 0);
        check_eq("wr_count_3", wr_count, 32'd3);
        check_eq("rd_count_2", rd_count, 32'd2);

        // Out-of-range read and write: zero data, err set, write dropped (no wrap onto 0x10).
        do_req(32'h1000, 32'h0, 4'b0000, 32'h0, 4, 0);
        check_eq("oor_err", {31'd0, err}, 32'd1);
        do_req(32'h1010, 32'h55555555, 4'b1111, 32'h0, 4, 0);
        do_req(32'h10, 32'h0, 4'b0000, 32'hDEADBEEF, 4, 0);

        // Reset clears status but keeps memory contents.
        do_reset();
        #1;
        check_eq("reset_err_clear", {31'd0, err}, 32'd0);
        check_eq("reset_rd_count", rd_count, 32'd0);
        check_eq("reset_wr_count", wr_count, 32'd0);
        do_req(32'h10, 32'h0, 4'b0000, 32'hDEADBEEF, 4, 0);

        // Withdrawn request, then a normal one completes.
        do_abort(32'h0);
        do_req(32'h0, 32'h0, 4'b0000, 32'h00220044, 4, 0);
        check_eq("err_sticky", {31'd0, err}, 32'd1);

        // Reset during the wait of a write: no ready, no write, counters zero.
        @(negedge clk);
        addr  = 32'h10;
        wdata = 32'hCAFEF00D;
        wstrb = 4'b1111;
        valid = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        resetn = 1'b0;
        #1;
        check_eq("midrst_ready", {31'd0, ready}, 32'd0);
        check_eq("midrst_rd_count", rd_count, 32'd0);
        check_eq("midrst_wr_count", wr_count, 32'd0);
        check_eq("midrst_err", {31'd0, err}, 32'd0);
        valid = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        do_req(32'h10, 32'h0, 4'b0000, 32'hDEADBEEF, 4, 0);

        // LATENCY=0 instance: nominal t+2, then 3 stalled cycles push it to t+5.
        sel = 1'b1;
        do_req(32'h20, 32'hA5A5A5A5, 4'b1111, 32'hA5A5A5A5, 2, 0);
        do_req(32'h20, 32'h0, 4'b0000, 32'hA5A5A5A5, 5, 3);
        check_eq("lat0_rd_count", rd_count, 32'd1);
        check_eq("lat0_wr_count", wr_count, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/picorv32_mem_model.md
PICORV32_MEM_MODEL -- requirements
Module: picorv32_mem_model

Interface
REQ-001 The block SHALL have parameter MEMORY_WORDS, default 1024, number of 32-bit words (power of two, 16..2**30).
REQ-002 The block SHALL have parameter LATENCY, default 2, wait cycles before response (0..15).
REQ-003 The block SHALL have parameter [0:0] CHECK_RANGE, default 1, flagging out-of-range accesses.
REQ-004 The block SHALL have port clk, input, 1 bit: single clock, all state changes on the rising edge.
REQ-005 The block SHALL have port resetn, input, 1 bit: reset, asynchronous, active-low.
REQ-006 The block SHALL have port domem, input, 1 bit: stall gate; 0 freezes the latency countdown and blocks response.
REQ-007 The block SHALL have port mem_valid, input, 1 bit: CPU request.
REQ-008 The block SHALL have port mem_ready, output, 1 bit: registered one-cycle response strobe.
REQ-009 The block SHALL have port mem_addr, input, 32 bits: byte address; word index = mem_addr >> 2.
REQ-010 The block SHALL have port mem_wdata, input, 32 bits: write data.
REQ-011 The block SHALL have port mem_wstrb, input, 4 bits: byte write enables; 0000 = read.
REQ-012 The block SHALL have port mem_rdata, output, 32 bits: read data, valid while mem_ready=1.
REQ-013 The block SHALL have port err, output, 1 bit: sticky protocol/range error.
REQ-014 The block SHALL have ports rd_count and wr_count, output, 32 bits each: completed reads/writes, saturating.

Function
REQ-015 The FSM SHALL have states IDLE, WAIT, RESP.
REQ-016 In IDLE with mem_valid=1, the block SHALL capture addr/wdata/wstrb and load cnt=LATENCY, then enter WAIT.
REQ-017 In WAIT, domem=1 SHALL decrement cnt when nonzero; with cnt==0 and domem=1 the block SHALL enter RESP; domem=0 SHALL hold state and cnt.
REQ-018 With domem held 1, mem_ready SHALL be high exactly in cycle t+2+LATENCY, where t is the IDLE capture cycle.
REQ-019 In RESP, mem_ready SHALL be 1 for exactly one cycle, then the FSM SHALL return to IDLE.
REQ-020 A request held valid after RESP SHALL be treated as a new transaction.
REQ-021 A read SHALL present memory[captured index] on mem_rdata in the RESP cycle; mem_rdata SHALL be 0 outside RESP.
REQ-022 A write SHALL update only the strobed bytes, committed at the edge entering RESP; mem_rdata during a write RESP SHALL be the post-write word.
REQ-023 An index >= MEMORY_WORDS with CHECK_RANGE=1 SHALL read as 0, drop writes, still respond, and set err.
REQ-024 With CHECK_RANGE=0, the index SHALL be taken modulo MEMORY_WORDS (wrap-around).
REQ-025 mem_valid falling in WAIT SHALL set err, abort without write, and return to IDLE without mem_ready.
REQ-026 In the RESP cycle, rd_count SHALL increment on reads and wr_count on writes; each SHALL hold at 32'hFFFFFFFF.
REQ-027 err SHALL be sticky until reset.

Reset
REQ-028 resetn=0 SHALL asynchronously force IDLE, cnt=0, mem_ready=0, mem_rdata=0, err=0, rd_count=0 and wr_count=0.
REQ-029 Reset mid-transaction SHALL drop the transaction (no write, no ready).
REQ-030 Memory contents SHALL NOT be cleared by reset.

Structure
REQ-031 Package picorv32_mem_pkg SHALL hold the state enum, WORD_W=32, STRB_W=4 and the counter width.
REQ-032 The storage SHALL be the sub-module picorv32_mem_array: single port, synchronous byte-strobed write, asynchronous read, depth MEMORY_WORDS.
REQ-033 The FSM, latency counter, range check and statistics counters SHALL reside in the top module.

Verification
REQ-034 LATENCY=2, domem=1: write 0xDEADBEEF to 0x10 with strobe 1111, then read 0x10 -> ready in cycle t+4 each time, rdata=0xDEADBEEF, wr_count=1, rd_count=1.
REQ-035 Write 0x11223344 with strobe 0101 over 0x0 -> read returns 0x00220044 from an initial 0x0 word.
REQ-036 LATENCY=0, domem low for 3 cycles after capture -> ready delayed 3 cycles, count unchanged during the stall.
REQ-037 CHECK_RANGE=1, MEMORY_WORDS=1024, read 0x1000 -> ready, rdata=0, err=1.
REQ-038 Drop mem_valid in WAIT -> no ready, err=1, the next valid request completes normally.
REQ-039 Assert resetn=0 during WAIT of a write -> ready=0 immediately, the target word is unchanged, counters read 0.
